// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared state encoding and requester ids for mem_arbiter
package mem_arbiter_pkg;

    localparam int NB_STATE = 1;

    typedef enum logic [NB_STATE-1:0] {
        ST_IDLE  = 1'b0,
        ST_LOCK1 = 1'b1
    } state_t;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DBG = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester, response and memory-port bundle for mem_arbiter
interface mem_arbiter_if #(
    parameter int NB_DATA    = 32,
    parameter int N_ADDRESS  = 64,
    parameter int NB_ADDRESS = $clog2(N_ADDRESS)
);
    logic                  i_req0_valid;
    logic                  i_req0_we;
    logic [NB_ADDRESS-1:0] i_req0_addr;
    logic [NB_DATA-1:0]    i_req0_wdata;
    logic                  i_req1_valid;
    logic                  i_req1_we;
    logic [NB_ADDRESS-1:0] i_req1_addr;
    logic [NB_DATA-1:0]    i_req1_wdata;
    logic                  i_req1_lock;
    logic                  o_req0_ready;
    logic                  o_req1_ready;
    logic                  o_req0_rvalid;
    logic                  o_req1_rvalid;
    logic [NB_DATA-1:0]    o_req0_rdata;
    logic [NB_DATA-1:0]    o_req1_rdata;
    logic                  o_mem_w_en;
    logic [NB_ADDRESS-1:0] o_mem_w_addr;
    logic [NB_DATA-1:0]    o_mem_w_data;
    logic                  o_mem_r_en;
    logic [NB_ADDRESS-1:0] o_mem_r_addr;
    logic [NB_DATA-1:0]    i_mem_r_data;

    modport slave (
        input  i_req0_valid, i_req0_we, i_req0_addr, i_req0_wdata,
        input  i_req1_valid, i_req1_we, i_req1_addr, i_req1_wdata, i_req1_lock,
        input  i_mem_r_data,
        output o_req0_ready, o_req1_ready, o_req0_rvalid, o_req1_rvalid,
        output o_req0_rdata, o_req1_rdata,
        output o_mem_w_en, o_mem_w_addr, o_mem_w_data, o_mem_r_en, o_mem_r_addr
    );

    modport master (
        output i_req0_valid, i_req0_we, i_req0_addr, i_req0_wdata,
        output i_req1_valid, i_req1_we, i_req1_addr, i_req1_wdata, i_req1_lock,
        output i_mem_r_data,
        input  o_req0_ready, o_req1_ready, o_req0_rvalid, o_req1_rvalid,
        input  o_req0_rdata, o_req1_rdata,
        input  o_mem_w_en, o_mem_w_addr, o_mem_w_data, o_mem_r_en, o_mem_r_addr
    );

endinterface

// File: rtl/mem_arb_grant.sv
// rtl/mem_arb_grant.sv - combinational winner select; MEM_ARB_RR_EN selects round-robin
//                        conflict resolution instead of fixed CPU priority
module mem_arb_grant
    import mem_arbiter_pkg::*;
(
    input  state_t state,
    input  logic   req0_valid,
    input  logic   req1_valid,
`ifdef MEM_ARB_RR_EN
    input  logic   rr_ptr,
`endif
    output logic   gnt0,
    output logic   gnt1
);

    logic conflict_to_dbg;

`ifdef MEM_ARB_RR_EN
    // Pointer holds the last winner, so a conflict goes to the other side.
    assign conflict_to_dbg = (rr_ptr == REQ_CPU);
`else
    assign conflict_to_dbg = 1'b0;
`endif

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state == ST_LOCK1) begin
            gnt1 = req1_valid;
        end else if (req0_valid && req1_valid) begin
            gnt0 = ~conflict_to_dbg;
            gnt1 = conflict_to_dbg;
        end else begin
            gnt0 = req0_valid;
            gnt1 = req1_valid;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester arbiter for a 1R/1W memory with debug lock;
//                      MEM_ARB_RR_EN enables round-robin conflict resolution
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int NB_DATA    = 32,
    parameter int N_ADDRESS  = 64,
    parameter int NB_ADDRESS = $clog2(N_ADDRESS)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    mem_arbiter_if.slave  bus
);

    state_t                state;
    logic                  gnt0_raw, gnt1_raw, gnt0, gnt1;
    logic                  granted, winner, sel_we;
    logic [NB_ADDRESS-1:0] sel_addr;
    logic [NB_DATA-1:0]    sel_wdata;
    logic                  rvalid0_q, rvalid1_q;
    logic [NB_DATA-1:0]    rdata0_q, rdata1_q;
`ifdef MEM_ARB_RR_EN
    logic                  rr_ptr;
`endif

    mem_arb_grant u_grant (
        .state      (state),
        .req0_valid (bus.i_req0_valid),
        .req1_valid (bus.i_req1_valid),
`ifdef MEM_ARB_RR_EN
        .rr_ptr     (rr_ptr),
`endif
        .gnt0       (gnt0_raw),
        .gnt1       (gnt1_raw)
    );

    // Nothing may reach the memory while reset is held.
    assign gnt0    = gnt0_raw & ~i_rst;
    assign gnt1    = gnt1_raw & ~i_rst;
    assign granted = gnt0 | gnt1;
    assign winner  = gnt1 ? REQ_DBG : REQ_CPU;

    assign sel_we    = (winner == REQ_DBG) ? bus.i_req1_we    : bus.i_req0_we;
    assign sel_addr  = (winner == REQ_DBG) ? bus.i_req1_addr  : bus.i_req0_addr;
    assign sel_wdata = (winner == REQ_DBG) ? bus.i_req1_wdata : bus.i_req0_wdata;

    assign bus.o_req0_ready  = gnt0;
    assign bus.o_req1_ready  = gnt1;
    assign bus.o_req0_rvalid = rvalid0_q;
    assign bus.o_req1_rvalid = rvalid1_q;
    assign bus.o_req0_rdata  = rdata0_q;
    assign bus.o_req1_rdata  = rdata1_q;

    always_comb begin
        bus.o_mem_w_en   = 1'b0;
        bus.o_mem_w_addr = '0;
        bus.o_mem_w_data = '0;
        bus.o_mem_r_en   = 1'b0;
        bus.o_mem_r_addr = '0;
        if (granted && sel_we) begin
            bus.o_mem_w_en   = 1'b1;
            bus.o_mem_w_addr = sel_addr;
            bus.o_mem_w_data = sel_wdata;
        end else if (granted) begin
            bus.o_mem_r_en   = 1'b1;
            bus.o_mem_r_addr = sel_addr;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= ST_IDLE;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
`ifdef MEM_ARB_RR_EN
            rr_ptr    <= REQ_DBG;
`endif
        end else begin
            rvalid0_q <= gnt0 & ~bus.i_req0_we;
            rvalid1_q <= gnt1 & ~bus.i_req1_we;
            if (gnt0 && !bus.i_req0_we) rdata0_q <= bus.i_mem_r_data;
            if (gnt1 && !bus.i_req1_we) rdata1_q <= bus.i_mem_r_data;
`ifdef MEM_ARB_RR_EN
            if (granted) rr_ptr <= winner;
`endif
            case (state)
                ST_IDLE:  if (gnt1 && bus.i_req1_lock) state <= ST_LOCK1;
                ST_LOCK1: if (!bus.i_req1_lock)        state <= ST_IDLE;
            endcase
        end
    end

endmodule
